// File: rtl/dm_responder.sv
// Data-memory responder: one load/store at a time over a req/ready handshake,
// with LATENCY wait states and byte stores done internally as read-modify-write.
module dm_responder #(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        word_byte_sel,
  input  logic [9:0]  addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        busy,
  output logic [31:0] rdata
);

  // state | meaning
  // IDLE  | waiting for req; request fields captured on acceptance
  // WAIT  | counting down wait states; access happens on the cnt==0 edge
  // RESP  | ready pulse, rdata valid for loads
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        we_q;
  logic        bsel_q;
  logic [9:0]  addr_q;
  logic [31:0] wdata_q;
  logic        access;

  logic [31:0] mem [DEPTH_WORDS];
  logic [7:0]  idx;
  logic [4:0]  lane_ofs;
  logic [31:0] word;
  logic [7:0]  lane;
  logic [31:0] merged;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      IDLE: if (req) state_nxt = WAIT;
      WAIT: begin
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      bsel_q  <= 1'b0;
      addr_q  <= 10'd0;
      wdata_q <= 32'd0;
      rdata   <= 32'd0;
    end else begin
      if (state == IDLE && req) begin
        cnt     <= LAT4;
        we_q    <= we;
        bsel_q  <= word_byte_sel;
        addr_q  <= addr;
        wdata_q <= wdata;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !we_q)
        rdata <= bsel_q ? {24'd0, lane} : word;
    end
  end

  // Little-endian lane select; a byte store rewrites only its lane of the read word.
  always_comb begin
    idx      = addr_q[9:2];
    lane_ofs = {addr_q[1:0], 3'b000};
    word     = mem[idx];
    lane     = word[lane_ofs +: 8];
    merged   = word;
    merged[lane_ofs +: 8] = wdata_q[7:0];
  end

  // Storage is deliberately not reset; rst only blocks a commit on its edge.
  always_ff @(posedge clk) begin
    if (!rst && access && we_q)
      mem[idx] <= bsel_q ? merged : wdata_q;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the multicycle MIPS datapath: the memory-side end of the CPU's data-memory access interface. It accepts one load/store request at a time through a req/ready handshake and inserts a programmable number of wait states. It performs word and byte (lb/sb) accesses internally, with sb done as an internal read-modify-write so the CPU never merges bytes itself. It replaces the zero-wait data memory behind the ALU-output address register.

## Interface
- LATENCY, default 2: wait cycles inserted between acceptance and the access; legal range 0–15.
- DEPTH_WORDS, default 256: 32-bit words of storage; indexed by addr[9:2].
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load; captured with req.
- word_byte_sel  in  1  0 = word access, 1 = byte access; captured with req.
- addr  in  10  byte address; captured with req.
- wdata  in  32  store data; byte stores use wdata[7:0] only; captured with req.
- ready  out  1  one-cycle completion pulse; rdata is valid while it is high.
- busy  out  1  high in every state except IDLE.
- rdata  out  32  registered load result.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req=1 at an edge captures we, word_byte_sel, addr, wdata; loads cnt=LATENCY (4 bits); next state WAIT. req=0 leaves the block in IDLE.
- WAIT, cnt≠0: cnt decrements.
- WAIT, cnt==0, same edge: the memory access happens; next state RESP.
- Word load: rdata ← mem[addr[9:2]]; addr[1:0] ignored.
- Byte load: rdata ← {24'b0, lane}. Lane is selected by addr[1:0], little-endian: 0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24]. The CPU sign-extends rdata[7:0].
- Word store: mem[addr[9:2]] ← wdata; addr[1:0] ignored.
- Byte store: only the addressed lane of mem[addr[9:2]] is replaced by wdata[7:0]; the other three bytes are preserved. Read and write use the same word in the same edge.
- rdata is unchanged by stores and holds its last load value until the next load completes.
- RESP: ready=1 for exactly one cycle; next state IDLE unconditionally. req is ignored in RESP.
- Inputs are ignored after capture; changing req, addr or wdata in WAIT has no effect.
- Memory contents are not initialized or cleared by rst.

## Timing
- Reset values: state IDLE, ready=0, busy=0, rdata=32'h0, cnt=0.
- Acceptance edge E0 (IDLE, req=1):
  - busy is high from E0 until the edge that returns to IDLE.
  - The access and the store commit occur at edge E(LATENCY+1).
  - ready is high in the cycle after E(LATENCY+1), then drops at E(LATENCY+2).
- Throughput: at most one request every LATENCY+3 cycles. With req held high continuously, the next request is accepted at E(LATENCY+3).
- LATENCY=0: access at E1, ready high in the cycle after E1.
- Reset mid-operation: rst has priority at every edge.
  - A store whose commit edge coincides with rst=1 does not commit.
  - The pending request is dropped, outputs return to reset values, and no ready is issued.
- A load immediately following a store to the same word returns the stored data; the store has already committed before the load is accepted.

## Test plan
- Reset: drive rst=1 for 2 cycles, then release → ready=0, busy=0, rdata=0; with req=0, the block stays IDLE indefinitely.
- Word round trip (LATENCY=2):
  - Store 32'hDEADBEEF to addr 10'h010 at E0 → busy=1 E0–E4; ready high only in the cycle after E3.
  - Load from 10'h010 → rdata=32'hDEADBEEF when ready is high; rdata holds that value afterwards.
- Byte lanes:
  - Word-store 32'h11223344 to 10'h020, then sb wdata=32'h000000AA to 10'h022 → a word load returns 32'h11AA3344.
  - lb from 10'h023 → rdata=32'h00000011; lb from 10'h020 → 32'h00000044.
- Handshake discipline: hold req=1 continuously with varying addr → one acceptance every LATENCY+3 cycles, using the addr present at each acceptance edge; changing addr/wdata during WAIT has no effect on the access.
- Reset mid-store: assert rst at the E3 edge of a store of 32'hFFFFFFFF to 10'h030 (word previously 32'h0) → no ready pulse; a later load returns 32'h00000000.
- LATENCY=0 build: a load accepted at E0 → ready high in the cycle after E1, with correct data.
